// File: rtl/router_pkg.sv
// Shared types and constants for the router read-side drain engine.
package router_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned LEN_W       = 6;
    localparam int unsigned BUF_DEPTH   = 2;
    localparam int unsigned OCC_W       = 2;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 2;
    // Address field occupies header bits [HDR_ADDR:0]
    localparam int unsigned HDR_ADDR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR_WAIT = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_PARITY   = 2'd3
    } rx_state_e;

    // One stream byte with its packet markers
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
    } rx_beat_t;

endpackage

// File: rtl/router_rx_skid.sv
// Two-entry tagged output buffer; the head entry drives the stream directly.
module router_rx_skid
    import router_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_push,
    input  rx_beat_t         i_beat,
    input  logic             i_pop,
    output rx_beat_t         o_head,
    output logic             o_valid,
    output logic [OCC_W-1:0] o_occ_c
);

    rx_beat_t   r_slot0;
    rx_beat_t   r_slot1;
    logic [1:0] r_vld;
    logic       w_pop;

    assign w_pop   = i_pop & r_vld[0];
    assign o_head  = r_slot0;
    assign o_valid = r_vld[0];
    assign o_occ_c = OCC_W'(r_vld[0]) + OCC_W'(r_vld[1]);

    // Shift-register buffer: pop advances slot1 into slot0, push fills the first free slot
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_vld   <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b11: begin
                    if (r_vld[1]) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_beat;
                    end else begin
                        r_slot0 <= i_beat;
                    end
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_vld   <= {1'b0, r_vld[1]};
                end
                2'b10: begin
                    if (!r_vld[0]) begin
                        r_slot0  <= i_beat;
                        r_vld[0] <= 1'b1;
                    end else begin
                        r_slot1  <= i_beat;
                        r_vld[1] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/router_rx_port.sv
// Read-side drain engine for one router output port: reads the port FIFO,
// reassembles header/payload/parity, checks parity and address, counts packets.
// Optional mid-packet starvation abort is enabled by ROUTER_RX_TIMEOUT_EN.
module router_rx_port
    import router_pkg::*;
#(
    parameter logic [1:0]  PORT_ID = 2'd0,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_enb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_err,
    output logic              pkt_done,
    output logic [15:0]       pkt_cnt,
    output logic [7:0]        err_cnt,
    output logic              timeout_err
);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_iss_cnt;
    logic [LEN_W-1:0]  r_arr_cnt;
    logic [DATA_W-1:0] r_par;
    logic              r_addr_bad;
    logic              r_inflight;
    logic              r_par_issued;
    logic              r_pkt_done;
    logic [15:0]       r_pkt_cnt;
    logic [7:0]        r_err_cnt;

    logic              w_pop;
    logic              w_credit;
    logic              w_rd_ok;
    logic              w_hdr_arr;
    logic              w_pay_arr;
    logic              w_par_arr;
    logic              w_timeout;
    logic              w_err_inc;
    rx_beat_t          w_beat;
    rx_beat_t          w_head;
    logic [OCC_W-1:0]  w_occ;

    // Output buffer
    router_rx_skid u_skid (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (r_inflight),
        .i_beat  (w_beat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (m_valid),
        .o_occ_c (w_occ)
    );

    assign m_data   = w_head.data;
    assign m_sop    = w_head.sop;
    assign m_eop    = w_head.eop;
    assign m_err    = w_head.err;
    assign pkt_done = r_pkt_done;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;

    // Credit: buffered + outstanding - leaving must stay below the buffer depth
    assign w_pop    = m_valid & m_ready;
    assign w_credit = (3'(w_occ) + 3'(r_inflight)) < (3'(BUF_DEPTH) + 3'(w_pop));
    assign w_rd_ok  = vld_out & w_credit & resetn;

    // Classify the byte arriving this cycle (read issued last cycle)
    assign w_hdr_arr = r_inflight & (r_state == ST_HDR_WAIT);
    assign w_par_arr = r_inflight & (r_state == ST_PARITY) & (r_arr_cnt == r_len);
    assign w_pay_arr = r_inflight & ((r_state == ST_PAYLOAD) |
                                     ((r_state == ST_PARITY) & (r_arr_cnt != r_len)));

    assign w_beat.data = data_out;
    assign w_beat.sop  = w_hdr_arr;
    assign w_beat.eop  = w_par_arr;
    assign w_beat.err  = w_par_arr & ((data_out != r_par) | r_addr_bad);

`ifdef ROUTER_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    logic            w_stall;

    assign w_stall     = ((r_state == ST_PAYLOAD) | (r_state == ST_PARITY)) &
                         ~vld_out & ~r_inflight;
    assign w_timeout   = w_stall & (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;

    // Consecutive starved cycles inside a packet
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_stall && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                       r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 32'd0);
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and read strobe
    always_comb begin
        w_state_nxt = r_state;
        read_enb    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                read_enb = w_rd_ok;
                if (w_rd_ok) w_state_nxt = ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                if (w_hdr_arr) begin
                    if (data_out[HDR_LEN_MSB:HDR_LEN_LSB] == '0) w_state_nxt = ST_PARITY;
                    else                                         w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                read_enb = w_rd_ok;
                if (w_rd_ok && (r_iss_cnt == r_len - LEN_W'(1))) w_state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                read_enb = w_rd_ok & ~r_par_issued;
                if (w_par_arr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = ST_IDLE;
    end

    assign w_err_inc = (w_par_arr & w_beat.err) | w_timeout;

    // Packet datapath: header fields, running parity, issue/arrival counts, statistics
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_len        <= '0;
            r_iss_cnt    <= '0;
            r_arr_cnt    <= '0;
            r_par        <= '0;
            r_addr_bad   <= 1'b0;
            r_inflight   <= 1'b0;
            r_par_issued <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_inflight <= read_enb;
            r_pkt_done <= w_par_arr;
            if (r_state != ST_PARITY) r_par_issued <= 1'b0;
            else if (read_enb)        r_par_issued <= 1'b1;
            if (w_hdr_arr) begin
                r_len      <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                r_addr_bad <= (data_out[HDR_ADDR:0] != PORT_ID);
                r_par      <= data_out;
                r_iss_cnt  <= '0;
                r_arr_cnt  <= '0;
            end
            if (w_pay_arr) begin
                r_par     <= r_par ^ data_out;
                r_arr_cnt <= r_arr_cnt + LEN_W'(1);
            end
            if ((r_state == ST_PAYLOAD) && read_enb) r_iss_cnt <= r_iss_cnt + LEN_W'(1);
            if (w_par_arr) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: models the upstream router FIFO and a consumer,
// and checks the stream against packets built from the packet-format rules.
module tb_router_rx_port;

    localparam logic [1:0]  PID = 2'd1;
    localparam int unsigned TO  = 32;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        vld_out = 1'b0;
    logic [7:0]  data_out = 8'h00;
    logic        read_enb;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_sop, m_eop, m_err, pkt_done, timeout_err;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    router_rx_port #(.PORT_ID(PID), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .vld_out     (vld_out),
        .data_out    (data_out),
        .read_enb    (read_enb),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_err       (m_err),
        .pkt_done    (pkt_done),
        .pkt_cnt     (pkt_cnt),
        .err_cnt     (err_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  fifo_q[$];
    logic [10:0] exp_q[$];
    bit          gate = 1'b1;
    bit          flicker = 1'b0;
    int          ready_mode = 0;
    int          cyc = 0;
    bit          rd_pending = 1'b0;
    bit          del_now = 1'b0;
    int          occ_m = 0;
    int          occ_max = 0;
    int          n_done = 0;
    int          n_reads = 0;
    int          n_to = 0;
    int          exp_pkt = 0;
    int          exp_err = 0;
    logic [10:0] got_beat, want_beat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO and consumer ready, driven just after each rising edge
    always @(posedge clock) begin
        #1;
        cyc++;
        del_now = 1'b0;
        if (!resetn) begin
            rd_pending = 1'b0;
        end else if (rd_pending) begin
            rd_pending = 1'b0;
            if (fifo_q.size() > 0) begin
                data_out = fifo_q.pop_front();
                del_now  = 1'b1;
            end
        end
        vld_out = gate && (fifo_q.size() > 0) && (!flicker || ($urandom_range(0, 3) != 0));
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc / 3) % 2) == 0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Observe the DUT between edges
    always @(negedge clock) begin
        if (resetn) begin
            if (read_enb) begin
                n_reads++;
                n_tests++;
                assert (fifo_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL rd_empty: read_enb=1 with fifo size %0d required >0", fifo_q.size());
                end
                rd_pending = 1'b1;
            end
            if (pkt_done) n_done++;
            if (timeout_err) n_to++;
            if (m_valid && m_ready) begin
                got_beat = {m_data, m_sop, m_eop, m_eop & m_err};
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL beat_extra: got %h required no beat", got_beat);
                end
                if (exp_q.size() > 0) begin
                    want_beat = exp_q.pop_front();
                    n_tests++;
                    assert (got_beat === want_beat) else begin
                        n_fail++;
                        $error("FAIL beat: got %h required %h", got_beat, want_beat);
                    end
                end
            end
            occ_m = occ_m + int'(del_now) - int'(m_valid && m_ready);
            if (occ_m > occ_max) occ_max = occ_m;
        end
    end

    // Build a packet from the format rules; queue its bytes upstream and its expected beats
    task automatic send_pkt(input int len, input logic [1:0] addr, input logic [7:0] flip,
                            input bit directed, input int trunc);
        logic [7:0] hdr, par, p;
        bit         bad;
        int         n_pay;
        hdr   = {6'(len), addr};
        par   = hdr;
        n_pay = (trunc >= 0) ? trunc : len;
        fifo_q.push_back(hdr);
        exp_q.push_back({hdr, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < len; i++) begin
            p   = directed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            par = par ^ p;
            if (i < n_pay) begin
                fifo_q.push_back(p);
                exp_q.push_back({p, 1'b0, 1'b0, 1'b0});
            end
        end
        if (trunc < 0) begin
            bad = (flip != 8'h00) || (addr != PID);
            fifo_q.push_back(par ^ flip);
            exp_q.push_back({par ^ flip, 1'b0, 1'b1, bad});
            exp_pkt++;
            if (bad && exp_err < 255) exp_err++;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
        n_tests++;
        assert (k < budget) else begin
            n_fail++;
            $error("FAIL %s_drain: %0d beats left required 0", tag, exp_q.size());
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_pkt_done"}, 32'(n_done), 32'(exp_pkt));
        chk({tag, "_occ_max"}, 32'(occ_max <= 2), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_enb"}, 32'(read_enb), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_sop"}, 32'(m_sop), 32'd0);
        chk({tag, "_m_eop"}, 32'(m_eop), 32'd0);
        chk({tag, "_m_err"}, 32'(m_err), 32'd0);
        chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int r0, r1, k;
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Good packet, L=3, matching address
        send_pkt(3, PID, 8'h00, 1'b1, -1);
        wait_drain("good", 200);
        chk_counters("good");

        // Same packet, corrupted parity
        send_pkt(3, PID, 8'h01, 1'b1, -1);
        wait_drain("badpar", 200);
        chk_counters("badpar");

        // Zero-length packet to the wrong address
        send_pkt(0, 2'd2, 8'h00, 1'b0, -1);
        wait_drain("badaddr", 200);
        chk_counters("badaddr");

        // Longest packet with a stalling consumer
        ready_mode = 1;
        send_pkt(63, PID, 8'h00, 1'b0, -1);
        wait_drain("long", 1000);
        chk_counters("long");
        ready_mode = 0;

        // Upstream starvation for 10 cycles mid-payload
        send_pkt(20, PID, 8'h00, 1'b0, -1);
        repeat (8) @(negedge clock);
        gate = 1'b0;
        repeat (2) @(negedge clock);
        r0 = n_reads;
        repeat (8) @(negedge clock);
        r1 = n_reads;
        chk("gap_no_reads", 32'(r1 - r0), 32'd0);
        gate = 1'b1;
        wait_drain("gap", 400);
        chk_counters("gap");
        chk("gap_no_timeout", 32'(n_to), 32'd0);

        // Back-to-back random packets with random upstream and consumer stalls
        ready_mode = 2;
        flicker    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_pkt(int'($urandom_range(0, 63)),
                     ($urandom_range(0, 2) != 0) ? PID : 2'($urandom),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                     1'b0, -1);
        end
        wait_drain("rand", 6000);
        chk_counters("rand");
        ready_mode = 0;
        flicker    = 1'b0;

`ifdef ROUTER_RX_TIMEOUT_EN
        // Truncated packet: upstream runs dry mid-payload and stays empty
        r0 = n_to;
        send_pkt(10, PID, 8'h00, 1'b0, 4);
        k = 0;
        while (fifo_q.size() != 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        k = 0;
        while (!timeout_err && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk("to_latency_window", 32'((k >= 31) && (k <= 34)), 32'd1);
        @(negedge clock);
        chk("to_pulse_width", 32'(timeout_err), 32'd0);
        chk("to_pulse_count", 32'(n_to - r0), 32'd1);
        if (exp_err < 255) exp_err++;
        wait_drain("to_tail", 100);
        chk_counters("to");
        send_pkt(5, PID, 8'h00, 1'b0, -1);
        wait_drain("to_after", 200);
        chk_counters("to_after");
`endif

        // Asynchronous reset in the middle of a packet
        send_pkt(30, PID, 8'h00, 1'b0, -1);
        repeat (6) @(negedge clock);
        #3;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        fifo_q.delete();
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        n_done  = 0;
        occ_m   = 0;
        occ_max = 0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        send_pkt(3, PID, 8'h00, 1'b1, -1);
        wait_drain("postrst", 200);
        chk_counters("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
